// File: rtl/bg_fetch_sched_if.sv
// Bundle between the PPU timing/register side, the BG fetch scheduler and the BG units.
// master = scheduler side, slave = timing generator / BG unit side.
interface bg_fetch_sched_if;
  logic        dot_en;
  logic        line_start;
  logic [2:0]  bgmode;
  logic [3:0]  bg_enable;
  logic        force_blank;
  logic [8:0]  x;
  logic        newline;
  logic [3:0]  fetch_map;
  logic [3:0]  fetch_data;
  logic [11:0] fetch_data_num;
  logic [11:0] bg_mode;
  logic [1:0]  vram_sel;
  logic        vram_sel_valid;

  modport master (
    input  dot_en, line_start, bgmode, bg_enable, force_blank,
    output x, newline, fetch_map, fetch_data, fetch_data_num, bg_mode,
           vram_sel, vram_sel_valid
  );

  modport slave (
    output dot_en, line_start, bgmode, bg_enable, force_blank,
    input  x, newline, fetch_map, fetch_data, fetch_data_num, bg_mode,
           vram_sel, vram_sel_valid
  );
endinterface

// File: rtl/bg_fetch_sched.sv
// Per-scanline VRAM slot scheduler for the four BG fetch units: runs the fetch-x
// counter and decodes each 8-dot group into per-BG map/data strobes from the latched BG mode.
module bg_fetch_sched #(
  parameter int FETCH_WIDTH = 264
) (
  input logic              clk,
  input logic              reset,
  bg_fetch_sched_if.master bus
);

  localparam logic [8:0] X_LAST = 9'(FETCH_WIDTH - 1);

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_MAP  = 2'd1,
    SLOT_DATA = 2'd2,
    SLOT_OPT  = 2'd3
  } slot_kind_e;

  typedef struct packed {
    slot_kind_e  kind;
    logic [1:0]  owner;
    logic [2:0]  num;
  } slot_t;

  function automatic slot_t f_idle();
    return '{kind: SLOT_IDLE, owner: 2'd0, num: 3'd0};
  endfunction

  function automatic slot_t f_map(input logic [1:0] owner);
    return '{kind: SLOT_MAP, owner: owner, num: 3'd0};
  endfunction

  function automatic slot_t f_data(input logic [1:0] owner, input logic [2:0] num);
    return '{kind: SLOT_DATA, owner: owner, num: num};
  endfunction

  // Offset-per-tile fetches always belong to BG3; num[0] selects H (0) or V (1).
  function automatic slot_t f_opt(input logic [2:0] num);
    return '{kind: SLOT_OPT, owner: 2'd2, num: num};
  endfunction

  logic [8:0] x_reg;
  logic       active_reg;
  logic [2:0] mode_lat_reg;

  // Mode is only re-latched at group boundaries so a group never mixes two tables.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg        <= 9'd0;
      active_reg   <= 1'b0;
      mode_lat_reg <= 3'd7;
    end else if (bus.dot_en) begin
      if (bus.line_start) begin
        x_reg        <= 9'd0;
        active_reg   <= 1'b1;
        mode_lat_reg <= bus.bgmode;
      end else if (active_reg) begin
        if (x_reg[2:0] == 3'd7) begin
          mode_lat_reg <= bus.bgmode;
        end
        if (x_reg == X_LAST) begin
          active_reg <= 1'b0;
          x_reg      <= 9'd0;
        end else begin
          x_reg <= x_reg + 9'd1;
        end
      end
    end
  end

  logic [2:0] slot;
  slot_t      slot_cur;

  assign slot = x_reg[2:0];

  always_comb begin
    slot_cur = f_idle();
    unique case (mode_lat_reg)
      3'd0: begin
        if (slot[2]) slot_cur = f_data(slot[1:0], 3'd0);
        else         slot_cur = f_map(slot[1:0]);
      end
      3'd1: begin
        unique case (slot)
          3'd0: slot_cur = f_map(2'd0);
          3'd1: slot_cur = f_map(2'd1);
          3'd2: slot_cur = f_map(2'd2);
          3'd3: slot_cur = f_data(2'd0, 3'd0);
          3'd4: slot_cur = f_data(2'd0, 3'd2);
          3'd5: slot_cur = f_data(2'd1, 3'd0);
          3'd6: slot_cur = f_data(2'd1, 3'd2);
          3'd7: slot_cur = f_data(2'd2, 3'd0);
          default: slot_cur = f_idle();
        endcase
      end
      3'd2: begin
        unique case (slot)
          3'd0: slot_cur = f_opt(3'd0);
          3'd1: slot_cur = f_opt(3'd1);
          3'd2: slot_cur = f_map(2'd0);
          3'd3: slot_cur = f_map(2'd1);
          3'd4: slot_cur = f_data(2'd0, 3'd0);
          3'd5: slot_cur = f_data(2'd0, 3'd2);
          3'd6: slot_cur = f_data(2'd1, 3'd0);
          3'd7: slot_cur = f_data(2'd1, 3'd2);
          default: slot_cur = f_idle();
        endcase
      end
      3'd3: begin
        unique case (slot)
          3'd0: slot_cur = f_map(2'd0);
          3'd1: slot_cur = f_map(2'd1);
          3'd2: slot_cur = f_data(2'd0, 3'd0);
          3'd3: slot_cur = f_data(2'd0, 3'd2);
          3'd4: slot_cur = f_data(2'd0, 3'd4);
          3'd5: slot_cur = f_data(2'd0, 3'd6);
          3'd6: slot_cur = f_data(2'd1, 3'd0);
          3'd7: slot_cur = f_data(2'd1, 3'd2);
          default: slot_cur = f_idle();
        endcase
      end
      3'd4: begin
        unique case (slot)
          3'd0: slot_cur = f_opt(3'd0);
          3'd1: slot_cur = f_map(2'd0);
          3'd2: slot_cur = f_map(2'd1);
          3'd3: slot_cur = f_data(2'd0, 3'd0);
          3'd4: slot_cur = f_data(2'd0, 3'd2);
          3'd5: slot_cur = f_data(2'd0, 3'd4);
          3'd6: slot_cur = f_data(2'd0, 3'd6);
          3'd7: slot_cur = f_data(2'd1, 3'd0);
          default: slot_cur = f_idle();
        endcase
      end
      3'd5: begin
        unique case (slot)
          3'd0: slot_cur = f_map(2'd0);
          3'd1: slot_cur = f_map(2'd1);
          3'd2: slot_cur = f_data(2'd0, 3'd0);
          3'd3: slot_cur = f_data(2'd0, 3'd1);
          3'd4: slot_cur = f_data(2'd0, 3'd2);
          3'd5: slot_cur = f_data(2'd0, 3'd3);
          3'd6: slot_cur = f_data(2'd1, 3'd0);
          3'd7: slot_cur = f_data(2'd1, 3'd1);
          default: slot_cur = f_idle();
        endcase
      end
      3'd6: begin
        unique case (slot)
          3'd0: slot_cur = f_opt(3'd0);
          3'd1: slot_cur = f_opt(3'd1);
          3'd2: slot_cur = f_map(2'd0);
          3'd3: slot_cur = f_data(2'd0, 3'd0);
          3'd4: slot_cur = f_data(2'd0, 3'd1);
          3'd5: slot_cur = f_data(2'd0, 3'd2);
          3'd6: slot_cur = f_data(2'd0, 3'd3);
          default: slot_cur = f_idle();
        endcase
      end
      default: slot_cur = f_idle();
    endcase
  end

  logic owner_en;
  logic fire;

  // OPT slots serve BG1/BG2 scrolling, so they follow those enables rather than BG3's.
  assign owner_en = (slot_cur.kind == SLOT_OPT) ? (bus.bg_enable[0] | bus.bg_enable[1])
                                                : bus.bg_enable[slot_cur.owner];
  assign fire     = active_reg & ~bus.force_blank & (slot_cur.kind != SLOT_IDLE) & owner_en;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bg
      logic hit;
      assign hit = fire && (slot_cur.owner == 2'(gi));
      assign bus.fetch_map[gi]          = hit && ((slot_cur.kind == SLOT_MAP) ||
                                                  (slot_cur.kind == SLOT_OPT));
      assign bus.fetch_data[gi]         = hit && (slot_cur.kind == SLOT_DATA);
      assign bus.fetch_data_num[3*gi +: 3] = hit ? slot_cur.num : 3'd0;
    end
  endgenerate

  assign bus.x              = x_reg;
  assign bus.newline        = active_reg && (x_reg == 9'd0);
  assign bus.vram_sel       = fire ? slot_cur.owner : 2'd0;
  assign bus.vram_sel_valid = fire;

  // Packed as {BG4, BG3, BG2, BG1}; mode 7 (also the reset value) leaves every BG at 000.
  logic [11:0] bg_mode_w;

  always_comb begin
    bg_mode_w = 12'd0;
    unique case (mode_lat_reg)
      3'd0:    bg_mode_w = {3'b001, 3'b001, 3'b001, 3'b001};
      3'd1:    bg_mode_w = {3'b000, 3'b001, 3'b010, 3'b010};
      3'd2:    bg_mode_w = {3'b000, 3'b000, 3'b010, 3'b010};
      3'd3:    bg_mode_w = {3'b000, 3'b000, 3'b010, 3'b011};
      3'd4:    bg_mode_w = {3'b000, 3'b100, 3'b001, 3'b011};
      3'd5:    bg_mode_w = {3'b000, 3'b000, 3'b101, 3'b110};
      3'd6:    bg_mode_w = {3'b000, 3'b000, 3'b000, 3'b110};
      default: bg_mode_w = 12'd0;
    endcase
  end

  assign bus.bg_mode = bg_mode_w;

endmodule

// File: tb/tb_bg_fetch_sched.sv
// Self-checking bench for bg_fetch_sched: hand vectors, directed corner sequences and
// randomized lines compared against a table-based line model.
module tb_bg_fetch_sched;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bg_fetch_sched_if bus ();

  bg_fetch_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       used;
    logic       is_map;
    logic       opt;
    logic [1:0] bg;
    logic [2:0] num;
  } ent_t;

  ent_t       tbl [8][8];
  logic [2:0] bgm [8][4];

  function automatic ent_t e_map(input int n);
    return '{used: 1'b1, is_map: 1'b1, opt: 1'b0, bg: 2'(n - 1), num: 3'd0};
  endfunction
  function automatic ent_t e_dat(input int n, input int num);
    return '{used: 1'b1, is_map: 1'b0, opt: 1'b0, bg: 2'(n - 1), num: 3'(num)};
  endfunction
  function automatic ent_t e_opt(input int num);
    return '{used: 1'b1, is_map: 1'b1, opt: 1'b1, bg: 2'd2, num: 3'(num)};
  endfunction
  function automatic ent_t e_idl();
    return '{used: 1'b0, is_map: 1'b0, opt: 1'b0, bg: 2'd0, num: 3'd0};
  endfunction

  // Line model: position on the line, whether a line is running, and the table for this group.
  bit m_active;
  int m_x;
  int m_mode;

  task automatic model_reset();
    m_active = 0;
    m_x      = 0;
    m_mode   = 7;
  endtask

  task automatic model_dot(input bit ls);
    if (ls) begin
      m_active = 1;
      m_x      = 0;
      m_mode   = int'(bus.bgmode);
    end else if (m_active) begin
      if (m_x % 8 == 7) m_mode = int'(bus.bgmode);
      if (m_x == 263) begin
        m_active = 0;
        m_x      = 0;
      end else begin
        m_x = m_x + 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model x=%0d mode=%0d)", name, act, exp, m_x, m_mode);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t        e;
    bit          en;
    bit          fire;
    logic [3:0]  exp_map;
    logic [3:0]  exp_data;
    logic [11:0] exp_num;
    logic [11:0] exp_bgm;
    e        = tbl[m_mode][m_x % 8];
    en       = e.opt ? (bus.bg_enable[0] | bus.bg_enable[1]) : bus.bg_enable[e.bg];
    fire     = m_active && !bus.force_blank && e.used && en;
    exp_map  = (fire && e.is_map)  ? (4'b0001 << e.bg) : 4'd0;
    exp_data = (fire && !e.is_map) ? (4'b0001 << e.bg) : 4'd0;
    exp_num  = fire ? (12'(e.num) << (3 * int'(e.bg))) : 12'd0;
    exp_bgm  = {bgm[m_mode][3], bgm[m_mode][2], bgm[m_mode][1], bgm[m_mode][0]};
    chk({tag, ".x"},       32'(bus.x),              32'(m_x));
    chk({tag, ".newline"}, 32'(bus.newline),        32'(m_active && m_x == 0));
    chk({tag, ".map"},     32'(bus.fetch_map),      32'(exp_map));
    chk({tag, ".data"},    32'(bus.fetch_data),     32'(exp_data));
    chk({tag, ".num"},     32'(bus.fetch_data_num), 32'(exp_num));
    chk({tag, ".bg_mode"}, 32'(bus.bg_mode),        32'(exp_bgm));
    chk({tag, ".valid"},   32'(bus.vram_sel_valid), 32'(fire));
    if (fire) chk({tag, ".sel"}, 32'(bus.vram_sel), 32'(e.bg));
  endtask

  task automatic step(input bit ls, input bit en);
    @(negedge clk);
    bus.dot_en     = en;
    bus.line_start = ls;
    @(posedge clk);
    #1;
    bus.dot_en     = 1'b0;
    bus.line_start = 1'b0;
    if (en) model_dot(ls);
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [3:0]  bge;
    logic [3:0]  map;
    logic [3:0]  data;
    logic [11:0] num;
    logic [1:0]  sel;
    logic [11:0] bgm;
  } vec_t;

  vec_t vecs [16];
  int   cnt;

  initial begin
    tbl[0] = '{e_map(1), e_map(2), e_map(3), e_map(4), e_dat(1,0), e_dat(2,0), e_dat(3,0), e_dat(4,0)};
    tbl[1] = '{e_map(1), e_map(2), e_map(3), e_dat(1,0), e_dat(1,2), e_dat(2,0), e_dat(2,2), e_dat(3,0)};
    tbl[2] = '{e_opt(0), e_opt(1), e_map(1), e_map(2), e_dat(1,0), e_dat(1,2), e_dat(2,0), e_dat(2,2)};
    tbl[3] = '{e_map(1), e_map(2), e_dat(1,0), e_dat(1,2), e_dat(1,4), e_dat(1,6), e_dat(2,0), e_dat(2,2)};
    tbl[4] = '{e_opt(0), e_map(1), e_map(2), e_dat(1,0), e_dat(1,2), e_dat(1,4), e_dat(1,6), e_dat(2,0)};
    tbl[5] = '{e_map(1), e_map(2), e_dat(1,0), e_dat(1,1), e_dat(1,2), e_dat(1,3), e_dat(2,0), e_dat(2,1)};
    tbl[6] = '{e_opt(0), e_opt(1), e_map(1), e_dat(1,0), e_dat(1,1), e_dat(1,2), e_dat(1,3), e_idl()};
    tbl[7] = '{e_idl(), e_idl(), e_idl(), e_idl(), e_idl(), e_idl(), e_idl(), e_idl()};
    bgm[0] = '{3'b001, 3'b001, 3'b001, 3'b001};
    bgm[1] = '{3'b010, 3'b010, 3'b001, 3'b000};
    bgm[2] = '{3'b010, 3'b010, 3'b000, 3'b000};
    bgm[3] = '{3'b011, 3'b010, 3'b000, 3'b000};
    bgm[4] = '{3'b011, 3'b001, 3'b100, 3'b000};
    bgm[5] = '{3'b110, 3'b101, 3'b000, 3'b000};
    bgm[6] = '{3'b110, 3'b000, 3'b000, 3'b000};
    bgm[7] = '{3'b000, 3'b000, 3'b000, 3'b000};

    // Mode 1 with BG1-3 enabled, then mode 2 with only BG1/BG2 enabled (OPT still fires).
    vecs[0]  = '{3'd1, 4'b0111, 4'b0001, 4'b0000, 12'h000, 2'd0, 12'h052};
    vecs[1]  = '{3'd1, 4'b0111, 4'b0010, 4'b0000, 12'h000, 2'd1, 12'h052};
    vecs[2]  = '{3'd1, 4'b0111, 4'b0100, 4'b0000, 12'h000, 2'd2, 12'h052};
    vecs[3]  = '{3'd1, 4'b0111, 4'b0000, 4'b0001, 12'h000, 2'd0, 12'h052};
    vecs[4]  = '{3'd1, 4'b0111, 4'b0000, 4'b0001, 12'h002, 2'd0, 12'h052};
    vecs[5]  = '{3'd1, 4'b0111, 4'b0000, 4'b0010, 12'h000, 2'd1, 12'h052};
    vecs[6]  = '{3'd1, 4'b0111, 4'b0000, 4'b0010, 12'h010, 2'd1, 12'h052};
    vecs[7]  = '{3'd1, 4'b0111, 4'b0000, 4'b0100, 12'h000, 2'd2, 12'h052};
    vecs[8]  = '{3'd2, 4'b0011, 4'b0100, 4'b0000, 12'h000, 2'd2, 12'h012};
    vecs[9]  = '{3'd2, 4'b0011, 4'b0100, 4'b0000, 12'h040, 2'd2, 12'h012};
    vecs[10] = '{3'd2, 4'b0011, 4'b0001, 4'b0000, 12'h000, 2'd0, 12'h012};
    vecs[11] = '{3'd2, 4'b0011, 4'b0010, 4'b0000, 12'h000, 2'd1, 12'h012};
    vecs[12] = '{3'd2, 4'b0011, 4'b0000, 4'b0001, 12'h000, 2'd0, 12'h012};
    vecs[13] = '{3'd2, 4'b0011, 4'b0000, 4'b0001, 12'h002, 2'd0, 12'h012};
    vecs[14] = '{3'd2, 4'b0011, 4'b0000, 4'b0010, 12'h000, 2'd1, 12'h012};
    vecs[15] = '{3'd2, 4'b0011, 4'b0000, 4'b0010, 12'h010, 2'd1, 12'h012};

    reset           = 1'b1;
    bus.dot_en      = 1'b0;
    bus.line_start  = 1'b0;
    bus.bgmode      = 3'd0;
    bus.bg_enable   = 4'hf;
    bus.force_blank = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset");
    $display("txn reset: x=%0d bg_mode=%03h", bus.x, bus.bg_mode);

    // Reset mid-line, asserted together with line_start to show reset wins.
    step(1, 1);
    for (int i = 0; i < 100; i++) step(0, 1);
    chk("midline.x100", 32'(bus.x), 32'd100);
    @(negedge clk);
    reset          = 1'b1;
    bus.dot_en     = 1'b1;
    bus.line_start = 1'b1;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus.dot_en     = 1'b0;
    bus.line_start = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      check_all("post_reset");
    end
    $display("txn reset mid-line: x=%0d valid=%0d newline=%0d", bus.x, bus.vram_sel_valid, bus.newline);

    for (int i = 0; i < 16; i++) begin
      bus.bgmode    = vecs[i].mode;
      bus.bg_enable = vecs[i].bge;
      step(i % 8 == 0, 1);
      chk("vec.x",       32'(bus.x),              32'(i % 8));
      chk("vec.newline", 32'(bus.newline),        32'(i % 8 == 0));
      chk("vec.map",     32'(bus.fetch_map),      32'(vecs[i].map));
      chk("vec.data",    32'(bus.fetch_data),     32'(vecs[i].data));
      chk("vec.num",     32'(bus.fetch_data_num), 32'(vecs[i].num));
      chk("vec.sel",     32'(bus.vram_sel),       32'(vecs[i].sel));
      chk("vec.valid",   32'(bus.vram_sel_valid), 32'd1);
      chk("vec.bg_mode", 32'(bus.bg_mode),        32'(vecs[i].bgm));
      $display("txn vec %0d: mode=%0d x=%0d map=%b data=%b num=%03h sel=%0d",
               i, vecs[i].mode, bus.x, bus.fetch_map, bus.fetch_data, bus.fetch_data_num, bus.vram_sel);
    end

    // bgmode change mid-group takes effect only at the next group boundary.
    bus.bgmode    = 3'd3;
    bus.bg_enable = 4'hf;
    step(1, 1);
    check_all("mchg");
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) bus.bgmode = 3'd0;
      step(0, 1);
      check_all("mchg");
      if (i == 15) begin
        chk("mchg.bgm15",  32'(bus.bg_mode[2:0]), 32'(3'b011));
        chk("mchg.data15", 32'(bus.fetch_data),   32'(4'b0010));
      end
      if (i == 16) begin
        chk("mchg.bgm16", 32'(bus.bg_mode[2:0]), 32'(3'b001));
        chk("mchg.map16", 32'(bus.fetch_map),    32'(4'b0001));
      end
    end
    $display("txn mode change: x=%0d bg_mode=%03h", bus.x, bus.bg_mode);

    // Full line end, then a restart mid-line.
    bus.bgmode = 3'd1;
    step(1, 1);
    for (int i = 0; i < 263; i++) begin
      step(0, 1);
      check_all("full");
    end
    chk("full.x263", 32'(bus.x), 32'd263);
    step(0, 1);
    chk("end.x",       32'(bus.x),              32'd0);
    chk("end.newline", 32'(bus.newline),        32'd0);
    chk("end.valid",   32'(bus.vram_sel_valid), 32'd0);
    chk("end.strobes", 32'({bus.fetch_map, bus.fetch_data}), 32'd0);
    step(1, 1);
    for (int i = 0; i < 200; i++) step(0, 1);
    chk("restart.x200", 32'(bus.x), 32'd200);
    step(1, 1);
    chk("restart.x",       32'(bus.x),       32'd0);
    chk("restart.newline", 32'(bus.newline), 32'd1);
    check_all("restart");
    $display("txn full line and restart: x=%0d newline=%0d", bus.x, bus.newline);

    // Blanked lines: force_blank, then mode 7.
    for (int pass = 0; pass < 2; pass++) begin
      bus.force_blank = (pass == 0);
      bus.bgmode      = (pass == 0) ? 3'd0 : 3'd7;
      cnt = 0;
      step(1, 1);
      if (bus.vram_sel_valid) cnt++;
      for (int i = 0; i < 263; i++) begin
        step(0, 1);
        if (bus.vram_sel_valid) cnt++;
      end
      chk(pass == 0 ? "fblank.count" : "mode7.count", 32'(cnt), 32'd0);
      chk(pass == 0 ? "fblank.x" : "mode7.x", 32'(bus.x), 32'd263);
      $display("txn blank pass %0d: valid dots=%0d x=%0d", pass, cnt, bus.x);
    end
    bus.force_blank = 1'b0;
    step(0, 1);

    // Randomized lines with dot_en gaps, mid-line mode/enable/blank changes and restarts.
    for (int ln = 0; ln < 12; ln++) begin
      bus.bgmode      = 3'($urandom_range(0, 7));
      bus.bg_enable   = 4'($urandom);
      bus.force_blank = ($urandom % 5 == 0);
      step(1, 1);
      check_all("rand");
      for (int i = 0; i < 300; i++) begin
        if ($urandom % 16 == 0) bus.bgmode = 3'($urandom_range(0, 7));
        if ($urandom % 32 == 0) bus.bg_enable = 4'($urandom);
        if ($urandom % 64 == 0) bus.force_blank = ~bus.force_blank;
        step($urandom % 200 == 0, $urandom % 4 != 0);
        check_all("rand");
      end
      $display("txn random line %0d: mode_now=%0d en=%b x=%0d errors=%0d",
               ln, bus.bgmode, bus.bg_enable, bus.x, errors);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bg_fetch_sched.md
Name: bg_fetch_sched

Overview:
Per-scanline VRAM slot scheduler for the four BG fetch units. It runs the fetch-x counter (0–263) and decodes each 8-dot group into 8 VRAM slots from the current BG mode. It drives every BG unit's fetch_map/fetch_data/fetch_data_num/mode strobes and the VRAM address-mux select. It sits between the PPU timing generator and bg instances 0–3.

Parameters:
- FETCH_WIDTH, 264, dots per line on which fetches occur (x = 0..FETCH_WIDTH-1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- dot_en  in  1  dot clock enable; all state advances only when high
- line_start  in  1  sampled on dot_en; starts a fetch line at x=0
- bgmode  in  3  BGMODE register, 0–7
- bg_enable  in  4  per-BG enable (main|sub); bit0 = BG1
- force_blank  in  1  INIDISP force blank
- x  out  9  current fetch x, shared by all BG units
- newline  out  1  high for the dot where x==0 and active
- fetch_map  out  4  per-BG map/OPT fetch strobe
- fetch_data  out  4  per-BG tile-data fetch strobe
- fetch_data_num  out  12  per-BG 3-bit slot number; [3i+2:3i] = BG(i+1)
- bg_mode  out  12  per-BG 3-bit fetch format; encoding listed under Behaviour
- vram_sel  out  2  BG index owning the VRAM address this dot
- vram_sel_valid  out  1  a fetch occurs this dot

Behaviour:
- Reset: active=0, x=0, mode_lat=7. All strobes, newline and vram_sel_valid are 0. bg_mode outputs are 0. Reset overrides line_start.
- Counter, all updates on dot_en only:
  - line_start=1: x<=0, active<=1, mode_lat<=bgmode. A restart mid-line is legal and aborts the current group.
  - Else if active and x==FETCH_WIDTH-1: active<=0, x<=0.
  - Else if active: x<=x+1.
- Mode latch:
  - mode_lat<=bgmode on dot_en when active and x[2:0]==7.
  - A bgmode change never alters a group in progress.
- Slot = x[2:0]. All outputs are combinational decodes of registered x, active and mode_lat, so they are valid for the whole dot.
- Slot tables, slots 0→7 ("Bn map"; "Bn d" followed by fetch_data_num; "idle" means no strobe):
  - Mode 0: B1 map, B2 map, B3 map, B4 map, B1 d000, B2 d000, B3 d000, B4 d000
  - Mode 1: B1 map, B2 map, B3 map, B1 d000, B1 d010, B2 d000, B2 d010, B3 d000
  - Mode 2: B3 opt num000, B3 opt num001, B1 map, B2 map, B1 d000, B1 d010, B2 d000, B2 d010
  - Mode 3: B1 map, B2 map, B1 d000, d010, d100, d110, B2 d000, d010
  - Mode 4: B3 opt num000, B1 map, B2 map, B1 d000, d010, d100, d110, B2 d000
  - Mode 5: B1 map, B2 map, B1 d000, d001, d010, d011, B2 d000, d001
  - Mode 6: B3 opt num000, B3 opt num001, B1 map, B1 d000, d001, d010, d011, idle
  - Mode 7: all slots idle
- OPT slots assert fetch_map with fetch_data_num[0] = 0 for H, 1 for V.
- fetch_data_num is 0 for any BG not strobed this dot.
- bg_mode per BG, by mode_lat:
  - mode 0: all four 001
  - mode 1: B1/B2 010, B3 001
  - mode 2: B1/B2 010, B3 000
  - mode 3: B1 011, B2 010
  - mode 4: B1 011, B2 001, B3 100
  - mode 5: B1 110, B2 101
  - mode 6: B1 110, B3 000
  - unused BGs: 000
- Suppression:
  - A slot is idle if active=0, force_blank=1, or the owning BG's bg_enable bit is 0.
  - OPT slots (BG3) in modes 2/4/6 fire whenever BG1 or BG2 is enabled, regardless of bg_enable[2].
  - Suppressed slots keep x counting.
- vram_sel = index (0–3) of the strobed BG; vram_sel_valid = OR of all strobes. At most one strobe is high per dot, by construction.
- newline = active & (x==0). It does not depend on force_blank.

Test Plan:
- Reset mid-line (x=100), then dot_en pulses without line_start → x=0, all strobes 0, newline 0.
- line_start, bgmode=1, bg_enable=4'b0111, 8 dots → slot 3 shows fetch_data[0]=1 with num 000; slot 4 shows num 010; slot 7 shows fetch_data[2]=1 with num 000; vram_sel sequence 0,1,2,0,0,1,1,2.
- bgmode=3, then change bgmode to 0 at x=10 → dots 10–15 keep the mode-3 table; x=16 onward uses the mode-0 table; bg_mode[2:0] switches 011→001 at x=16.
- bgmode=2, bg_enable=4'b0011 → slots 0 and 1 strobe fetch_map[2] with num 000/001; bg_mode[8:6]=000.
- Run a full line → x reaches 263; the next dot gives active=0 and no strobes. line_start at x=200 → x restarts at 0 with newline=1.
- force_blank=1 or bgmode=7 → vram_sel_valid stays 0 for all 264 dots while x still counts.
